// File: rtl/des_iterative_core_if.sv
// Block handshake bundle for des_iterative_core: input offer side, result side, and status.
interface des_iterative_core_if;
    logic        in_valid;
    logic        in_ready;
    logic        decrypt;
    logic [63:0] key;
    logic [63:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
    logic        busy;

    modport master (
        output in_valid, decrypt, key, data_in, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, decrypt, key, data_in, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/des_iterative_core.sv
// Iterative DES encrypt/decrypt engine; ROUNDS_PER_CYCLE Feistel rounds per clock,
// key schedule rotated on the fly so no subkey storage is needed.
module des_iterative_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input logic clk,
    input logic rst,
    des_iterative_core_if.slave bus
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : gBadRoundsPerCycle
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
        59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
        35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
        12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
        24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
        10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
        7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
        23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55,
        30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Tables use DES numbering: entry n selects bit n counted from the MSB, starting at 1.
    function automatic logic [63:0] ipPerm(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return r;
    endfunction

    function automatic logic [63:0] fpPerm(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return r;
    endfunction

    function automatic logic [55:0] pc1Perm(input logic [63:0] x);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) r[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return r;
    endfunction

    function automatic logic [47:0] pc2Perm(input logic [55:0] x);
        logic [47:0] r;
        r = '0;
        for (int unsigned i = 0; i < 48; i++) r[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return r;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        x = '0;
        for (int unsigned i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
        x = x ^ k;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            six = x[47:42];
            x   = x << 6;
            s   = {s[27:0], 4'(SBOX[3'(i)][{six[5], six[0], six[4:1]}])};
        end
        p = '0;
        for (int unsigned i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
        return p;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT       state;
    logic [31:0] lReg, rReg, lNext, rNext, rPrev;
    logic [27:0] cReg, dReg, cNext, dNext;
    logic [4:0]  roundCnt, roundIdx;
    logic [47:0] subkey;
    logic        modeDec, oneStep;
    logic        inReadyQ, outValidQ, busyQ;
    logic [63:0] dataOutQ;

    // Decrypt rotates right before PC2 (by 0 on round 1), so round 1 sees C16 == C0.
    always_comb begin
        lNext    = lReg;
        rNext    = rReg;
        cNext    = cReg;
        dNext    = dReg;
        roundIdx = '0;
        subkey   = '0;
        rPrev    = '0;
        oneStep  = 1'b0;
        for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            roundIdx = roundCnt + 5'(j) + 5'd1;
            if (!modeDec) begin
                oneStep = (roundIdx == 5'd1) || (roundIdx == 5'd2) ||
                          (roundIdx == 5'd9) || (roundIdx == 5'd16);
                cNext = rotl(cNext, !oneStep);
                dNext = rotl(dNext, !oneStep);
            end else if (roundIdx != 5'd1) begin
                oneStep = (roundIdx == 5'd2) || (roundIdx == 5'd9) || (roundIdx == 5'd16);
                cNext = rotr(cNext, !oneStep);
                dNext = rotr(dNext, !oneStep);
            end
            subkey = pc2Perm({cNext, dNext});
            rPrev  = rNext;
            rNext  = lNext ^ feistel(rNext, subkey);
            lNext  = rPrev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lReg      <= '0;
            rReg      <= '0;
            cReg      <= '0;
            dReg      <= '0;
            roundCnt  <= '0;
            modeDec   <= 1'b0;
            dataOutQ  <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    {lReg, rReg} <= ipPerm(bus.data_in);
                    {cReg, dReg} <= pc1Perm(bus.key);
                    modeDec      <= bus.decrypt;
                    roundCnt     <= '0;
                    state        <= RUN;
                    inReadyQ     <= 1'b0;
                    busyQ        <= 1'b1;
                end
                RUN: begin
                    lReg     <= lNext;
                    rReg     <= rNext;
                    cReg     <= cNext;
                    dReg     <= dNext;
                    roundCnt <= roundCnt + 5'(ROUNDS_PER_CYCLE);
                    if (roundCnt + 5'(ROUNDS_PER_CYCLE) == 5'd16) begin
                        dataOutQ  <= fpPerm({rNext, lNext});
                        state     <= DONE;
                        outValidQ <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state     <= IDLE;
                    outValidQ <= 1'b0;
                    inReadyQ  <= 1'b1;
                    busyQ     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = outValidQ;
    assign bus.busy      = busyQ;
    assign bus.data_out  = dataOutQ;

endmodule

// File: tb/tb_des_iterative_core.sv
// Directed bench for des_iterative_core: known-answer vectors, handshake timing,
// backpressure, mid-run reset and a sweep over the unroll factors.
module tb_des_iterative_core;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_A   = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_A   = 64'h85E813540F0AB405;
    localparam logic [63:0] CT_0   = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] KEY_P  = 64'h0101010101010101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned nCmp = 0;
    int unsigned nBad = 0;

    des_iterative_core_if dutIf();
    des_iterative_core #(.ROUNDS_PER_CYCLE(1)) dut (.clk(clk), .rst(rst), .bus(dutIf));

    logic        swInValid, swDecrypt, swOutReady;
    logic [63:0] swKey, swData;
    logic        swOutValid [4];
    logic        swInReady  [4];
    logic        swBusy     [4];
    logic [63:0] swDataOut  [4];

    for (genvar g = 0; g < 4; g++) begin : gSweep
        des_iterative_core_if swIf();
        des_iterative_core #(.ROUNDS_PER_CYCLE(2 << g)) u (.clk(clk), .rst(rst), .bus(swIf));
        assign swIf.in_valid  = swInValid;
        assign swIf.decrypt   = swDecrypt;
        assign swIf.key       = swKey;
        assign swIf.data_in   = swData;
        assign swIf.out_ready = swOutReady;
        assign swOutValid[g]  = swIf.out_valid;
        assign swInReady[g]   = swIf.in_ready;
        assign swBusy[g]      = swIf.busy;
        assign swDataOut[g]   = swIf.data_out;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits up to 40 edges for out_valid; lat = edges after the accept edge.
    task automatic waitResult(input bit toggle, output logic [63:0] res, output int lat);
        lat = 0;
        res = '0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (dutIf.out_valid) begin
                lat = e;
                res = dutIf.data_out;
                if (toggle) dutIf.in_valid = 1'b0;
                break;
            end
            if (toggle) begin
                dutIf.in_valid = 1'($urandom_range(0, 1));
                dutIf.key      = {$urandom, $urandom};
                dutIf.data_in  = {$urandom, $urandom};
                dutIf.decrypt  = 1'($urandom_range(0, 1));
            end
        end
    endtask

    logic [63:0] res;
    int          lat;
    logic [63:0] vKey [4];
    logic [63:0] vData[4];
    logic [63:0] vExp [4];
    logic        vDec [4];
    int          swLat[4];
    logic [63:0] swRes[4];

    initial begin
        dutIf.in_valid  = 1'b0;
        dutIf.decrypt   = 1'b0;
        dutIf.key       = '0;
        dutIf.data_in   = '0;
        dutIf.out_ready = 1'b1;
        swInValid = 1'b0; swDecrypt = 1'b0; swKey = '0; swData = '0; swOutReady = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(dutIf.in_ready), 64'd1);
        check("rst_out_valid", 64'(dutIf.out_valid), 64'd0);
        check("rst_busy", 64'(dutIf.busy), 64'd0);
        check("rst_data_out", dutIf.data_out, 64'd0);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("sw%0d_rst_in_ready", g), 64'(swInReady[g]), 64'd1);
            check($sformatf("sw%0d_rst_busy", g), 64'(swBusy[g]), 64'd0);
        end
        rst = 1'b0;

        // zero key, zero data encrypt
        dutIf.in_valid = 1'b1;
        @(negedge clk);
        dutIf.in_valid = 1'b0;
        check("t1_busy", 64'(dutIf.busy), 64'd1);
        check("t1_in_ready", 64'(dutIf.in_ready), 64'd0);
        waitResult(1'b0, res, lat);
        check("t1_result", res, CT_0);
        check("t1_latency", 64'(lat), 64'd16);

        // back-to-back encrypt then decrypt, out_ready tied high
        @(negedge clk);
        check("t2_idle_in_ready", 64'(dutIf.in_ready), 64'd1);
        check("t2_idle_out_valid", 64'(dutIf.out_valid), 64'd0);
        dutIf.key = KEY_A; dutIf.data_in = PT_A; dutIf.decrypt = 1'b0; dutIf.in_valid = 1'b1;
        @(negedge clk);
        check("t2_enc_in_ready", 64'(dutIf.in_ready), 64'd0);
        dutIf.decrypt = 1'b1; dutIf.data_in = CT_A;
        waitResult(1'b0, res, lat);
        check("t2_enc_result", res, CT_A);
        check("t2_enc_latency", 64'(lat), 64'd16);
        @(negedge clk);
        check("t2_gap_in_ready", 64'(dutIf.in_ready), 64'd1);
        check("t2_gap_out_valid", 64'(dutIf.out_valid), 64'd0);
        @(negedge clk);
        check("t2_dec_in_ready", 64'(dutIf.in_ready), 64'd0);
        check("t2_dec_busy", 64'(dutIf.busy), 64'd1);
        dutIf.in_valid = 1'b0;
        waitResult(1'b0, res, lat);
        check("t2_dec_result", res, PT_A);
        check("t2_dec_latency", 64'(lat), 64'd16);

        // parity bits ignored
        @(negedge clk);
        dutIf.key = KEY_P; dutIf.data_in = '0; dutIf.decrypt = 1'b0; dutIf.in_valid = 1'b1;
        @(negedge clk);
        dutIf.in_valid = 1'b0;
        waitResult(1'b0, res, lat);
        check("t3_parity_result", res, CT_0);

        // backpressure with input noise during RUN
        @(negedge clk);
        dutIf.out_ready = 1'b0;
        dutIf.key = KEY_A; dutIf.data_in = PT_A; dutIf.decrypt = 1'b0; dutIf.in_valid = 1'b1;
        @(negedge clk);
        waitResult(1'b1, res, lat);
        check("t4_result", res, CT_A);
        check("t4_latency", 64'(lat), 64'd16);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold%0d_data", i), dutIf.data_out, CT_A);
            check($sformatf("t4_hold%0d_valid", i), 64'(dutIf.out_valid), 64'd1);
            check($sformatf("t4_hold%0d_in_ready", i), 64'(dutIf.in_ready), 64'd0);
        end
        dutIf.out_ready = 1'b1;
        @(negedge clk);
        check("t4_release_valid", 64'(dutIf.out_valid), 64'd0);
        check("t4_release_in_ready", 64'(dutIf.in_ready), 64'd1);

        // reset after the 7th RUN edge
        dutIf.key = '0; dutIf.data_in = '0; dutIf.decrypt = 1'b0; dutIf.in_valid = 1'b1;
        @(negedge clk);
        dutIf.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_busy_before_rst", 64'(dutIf.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_out_valid", 64'(dutIf.out_valid), 64'd0);
        check("t5_rst_data_out", dutIf.data_out, 64'd0);
        check("t5_rst_in_ready", 64'(dutIf.in_ready), 64'd1);
        check("t5_rst_busy", 64'(dutIf.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dutIf.in_valid = 1'b1;
        @(negedge clk);
        dutIf.in_valid = 1'b0;
        waitResult(1'b0, res, lat);
        check("t5_after_rst_result", res, CT_0);
        check("t5_after_rst_latency", 64'(lat), 64'd16);

        // unroll sweep: 2, 4, 8, 16 rounds per cycle
        vKey[0] = '0;    vData[0] = '0;   vDec[0] = 1'b0; vExp[0] = CT_0;
        vKey[1] = KEY_A; vData[1] = PT_A; vDec[1] = 1'b0; vExp[1] = CT_A;
        vKey[2] = KEY_A; vData[2] = CT_A; vDec[2] = 1'b1; vExp[2] = PT_A;
        vKey[3] = KEY_P; vData[3] = '0;   vDec[3] = 1'b0; vExp[3] = CT_0;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            swKey = vKey[v]; swData = vData[v]; swDecrypt = vDec[v]; swInValid = 1'b1;
            @(negedge clk);
            swInValid = 1'b0;
            for (int g = 0; g < 4; g++) begin
                swLat[g] = 0;
                swRes[g] = '0;
            end
            for (int e = 1; e <= 20; e++) begin
                @(negedge clk);
                for (int g = 0; g < 4; g++) begin
                    if (swOutValid[g] && swLat[g] == 0) begin
                        swLat[g] = e;
                        swRes[g] = swDataOut[g];
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                check($sformatf("sw%0d_v%0d_result", g, v), swRes[g], vExp[v]);
                check($sformatf("sw%0d_v%0d_latency", g, v), 64'(swLat[g]), 64'(16 >> (g + 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
